// File: rtl/twos_acc_pkg.sv
// twos_acc_pkg: shared state encoding, sample width and sign extension for twos_accumulator
package twos_acc_pkg;
    localparam int SAMPLE_W = 4;
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;
    function automatic logic [63:0] sext(input logic [SAMPLE_W-1:0] s);
        return {{(64-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction
endpackage

// File: rtl/twos_accumulator_if.sv
// twos_accumulator_if: sample input and frame output handshakes plus frame abort
interface twos_accumulator_if import twos_acc_pkg::*; #(parameter int ACC_W = 6);
    logic                clear;
    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_W-1:0]    out_sum;
    logic                out_ovf;
    modport master (output clear, in_valid, in_data, out_ready, input in_ready, out_valid, out_sum, out_ovf);
    modport slave  (input clear, in_valid, in_data, out_ready, output in_ready, out_valid, out_sum, out_ovf);
endinterface

// File: rtl/twos_accumulator_sat_add.sv
// sat_add: signed add with overflow detect; clamps when TWOS_ACC_SAT_EN is defined, wraps otherwise
module sat_add #(parameter int ACC_W = 6) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] sample,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    logic [ACC_W-1:0] raw;
    assign raw = acc + sample;
    assign ovf = (acc[ACC_W-1] == sample[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef TWOS_ACC_SAT_EN
    assign sum = ovf ? (acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) : raw;
`else
    assign sum = raw;
`endif
endmodule

// File: rtl/twos_accumulator.sv
// twos_accumulator: sums COUNT sign-extended 4-bit samples per frame, holds sum and sticky overflow
// until taken; TWOS_ACC_SAT_EN selects clamping instead of wrapping
module twos_accumulator import twos_acc_pkg::*; #(
    parameter int COUNT = 8,
    parameter int ACC_W = 6
) (
    input logic               clk,
    input logic               rst,
    twos_accumulator_if.slave bus
);
    localparam int CW = $clog2(COUNT + 1);
    state_t           state;
    logic [ACC_W-1:0] acc, nsum, ext;
    logic [CW-1:0]    cnt;
    logic             ovf, add_ovf;
    assign ext = ACC_W'(sext(bus.in_data));
    sat_add #(.ACC_W(ACC_W)) u_add (.acc(acc), .sample(ext), .sum(nsum), .ovf(add_ovf));
    always_ff @(posedge clk) begin
        if (rst || bus.clear || (state == HOLD && bus.out_ready)) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (state == ACCUM && bus.in_valid) begin
            acc   <= nsum;
            ovf   <= ovf | add_ovf;
            cnt   <= cnt + CW'(1);
            state <= (cnt == CW'(COUNT - 1)) ? HOLD : ACCUM;
        end
    end
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_twos_accumulator.sv
// tb_twos_accumulator: table, hand-written and randomized frames against an integer reference model
module tb_twos_accumulator;
    localparam int COUNT = 8;
    localparam int ACC_W = 6;
    typedef struct {
        string            name;
        logic [31:0]      s;
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;
    always #5 clk = ~clk;
    twos_accumulator_if #(.ACC_W(ACC_W)) bus ();
    twos_accumulator #(.COUNT(COUNT), .ACC_W(ACC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string n);
        check({n, " in_ready"}, 32'(bus.in_ready), 1);
        check({n, " out_valid"}, 32'(bus.out_valid), 0);
        check({n, " out_sum"}, 32'(bus.out_sum), 0);
        check({n, " out_ovf"}, 32'(bus.out_ovf), 0);
    endtask

    // true-sum reference: each step is checked against the signed range, then clamped or folded
    function automatic void model(input logic [31:0] s, output logic [ACC_W-1:0] sum, output logic ovf);
        int acc, t;
        int hi, lo;
        logic signed [3:0] x;
        acc = 0;
        hi = (1 << (ACC_W - 1)) - 1;
        lo = -(1 << (ACC_W - 1));
        ovf = 1'b0;
        for (int i = 0; i < COUNT; i++) begin
            x = s[4*i +: 4];
            t = acc + int'(x);
            if (t > hi || t < lo) ovf = 1'b1;
`ifdef TWOS_ACC_SAT_EN
            acc = (t > hi) ? hi : (t < lo) ? lo : t;
`else
            acc = (t > hi) ? t - (1 << ACC_W) : (t < lo) ? t + (1 << ACC_W) : t;
`endif
        end
        sum = ACC_W'(acc);
    endfunction

    task automatic feed(input logic [31:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = s[4*i +: 4];
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] s, input bit gaps, input logic [ACC_W-1:0] es,
                             input logic eo, input string n);
        for (int i = 0; i < COUNT; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                bus.in_data = 4'($urandom);
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data = s[4*i +: 4];
            tick();
            if (i < COUNT - 1) check({n, " early out_valid"}, 32'(bus.out_valid), 0);
        end
        bus.in_valid = 1'b0;
        check({n, " out_valid"}, 32'(bus.out_valid), 1);
        check({n, " in_ready"}, 32'(bus.in_ready), 0);
        check({n, " out_sum"}, 32'(bus.out_sum), 32'(es));
        check({n, " out_ovf"}, 32'(bus.out_ovf), 32'(eo));
        if (gaps) repeat ($urandom_range(0, 3)) begin
            tick();
            check({n, " held sum"}, 32'(bus.out_sum), 32'(es));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_idle({n, " after take"});
    endtask

    vec_t vecs[5];
    logic [ACC_W-1:0] ms;
    logic mo;
    logic [31:0] rs;

    initial begin
        vecs[0] = '{"ones", 32'h1111_1111, 6'd8, 1'b0};
        vecs[1] = '{"alt7_9", 32'h9797_9797, 6'd0, 1'b0};
`ifdef TWOS_ACC_SAT_EN
        vecs[2] = '{"pos_ovf", 32'h7777_7777, 6'b011111, 1'b1};
        vecs[3] = '{"neg_ovf", 32'h8888_8888, 6'b100000, 1'b1};
`else
        vecs[2] = '{"pos_ovf", 32'h7777_7777, 6'b111000, 1'b1};
        vecs[3] = '{"neg_ovf", 32'h8888_8888, 6'b000000, 1'b1};
`endif
        vecs[4] = '{"minus1", 32'hFFFF_FFFF, 6'b111000, 1'b0};
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 4'd0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check_idle("reset");

        for (int i = 0; i < 5; i++) run_frame(vecs[i].s, 1'b0, vecs[i].sum, vecs[i].ovf, vecs[i].name);

        // HOLD stalls while in_valid keeps offering samples
        feed(32'h1111_1111, COUNT);
        bus.in_valid = 1'b1;
        bus.in_data = 4'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall out_valid", 32'(bus.out_valid), 1);
            check("stall in_ready", 32'(bus.in_ready), 0);
            check("stall out_sum", 32'(bus.out_sum), 8);
            check("stall out_ovf", 32'(bus.out_ovf), 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_idle("stall release");

        feed(32'h0000_0777, 3);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check_idle("mid clear");
        run_frame(32'hFFFF_FFFF, 1'b0, 6'b111000, 1'b0, "after clear");

        feed(32'h0000_0777, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("mid rst");
        run_frame(32'hFFFF_FFFF, 1'b0, 6'b111000, 1'b0, "after rst");

        feed(32'h7777_7777, COUNT);
        bus.clear = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.out_ready = 1'b0;
        check_idle("clear with take");
        run_frame(32'h1111_1111, 1'b0, 6'd8, 1'b0, "after clear take");

        for (int k = 0; k < 30; k++) begin
            rs = $urandom;
            model(rs, ms, mo);
            run_frame(rs, 1'b1, ms, mo, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/twos_accumulator.md
# twos_accumulator

Sequential stage directly downstream of the signed-magnitude to two's-complement converter. It accepts 4-bit two's-complement samples over a valid/ready handshake and sign-extends each one to `ACC_W` bits. It sums `COUNT` samples per frame and presents the frame sum with an overflow flag on a second valid/ready handshake. This gives the converter output a clocked consumer and makes the signed arithmetic observable.

## Interface
- `COUNT`, default 8: samples per frame; legal range is at least 1.
- `ACC_W`, default 6: accumulator and output width in bits; legal range is at least 4.

- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `clear` input 1: synchronous frame abort; same effect as `rst`.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the block can accept a sample.
- `in_data` input 4: two's-complement sample from the converter (O3..O0), range -8..7.
- `out_valid` output 1: `out_sum` and `out_ovf` hold a completed frame.
- `out_ready` input 1: the consumer takes the frame.
- `out_sum` output ACC_W: signed frame sum.
- `out_ovf` output 1: overflow occurred at least once during the frame.

## Operation
- FSM has two states, both registered:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Reset state, on `rst` or `clear`:
  - state = ACCUM, accumulator = 0, sample count = 0, overflow flag = 0.
  - Outputs after reset: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_ovf`=0.
- In ACCUM, a sample is accepted when `in_valid` and `in_ready` are both high on a clock edge.
  - The sample is sign-extended (bit 3 replicated) to `ACC_W` bits and added to the accumulator.
  - Signed overflow is detected when both operands have the same sign and the result sign differs. On overflow the overflow flag is set sticky.
  - The count increments. When the accepted sample is number `COUNT` (count was `COUNT`-1), the next state is HOLD.
- In HOLD:
  - `out_sum` equals the accumulator and `out_ovf` equals the overflow flag; both are held stable until the output handshake.
  - `in_valid` is ignored.
  - When `out_valid` and `out_ready` are both high: accumulator, count and flag clear, and the state returns to ACCUM.
- `out_sum` is driven directly from the accumulator in both states. It is not masked during ACCUM.
- Priority: `rst` > `clear` > output handshake > input acceptance.
- A `clear` in the same cycle as the output handshake discards the frame. Both yield the same reset state.
- `rst` or `clear` in the middle of a frame discards all partial data.

## Timing
- Throughput: one sample per cycle in ACCUM.
- `out_valid` rises on the edge at which the final sample is accepted. It is visible in the following cycle.
- `in_ready` is low for the whole of HOLD. It is therefore low on the cycle of the output handshake and returns high the cycle after.
- Minimum frame period: `COUNT`+1 cycles.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Configuration
- Macro: `TWOS_ACC_SAT_EN`.
- Defined: on overflow the accumulator clamps instead of wrapping.
  - Positive overflow clamps to 2^(ACC_W-1)-1.
  - Negative overflow clamps to -2^(ACC_W-1).
  - Once clamped, later samples keep adding from the clamped value.
- Undefined: the accumulator wraps modulo 2^ACC_W.
- `out_ovf` behaves identically in both builds.

## Structure
- Package `twos_acc_pkg` holds:
  - the state enum (ACCUM, HOLD);
  - the sample width constant `SAMPLE_W`=4;
  - a sign-extension function.
- Sub-module `sat_add`:
  - inputs: `ACC_W`-bit accumulator, sign-extended sample;
  - outputs: next sum, overflow;
  - the `TWOS_ACC_SAT_EN` clamp lives only in this sub-module.
- The top level holds the FSM, the count register, and the handshakes.

## Test plan
- Reset, then 8 samples of 0001 -> `out_valid`=1 the cycle after the 8th accept, `out_sum`=8, `out_ovf`=0.
- Alternate 0111 and 1001, 4 pairs -> `out_sum`=0, `out_ovf`=0.
- 8 samples of 0111 (true sum 56):
  - with `TWOS_ACC_SAT_EN` -> `out_sum`=011111 (31), `out_ovf`=1;
  - without -> `out_sum`=111000 (-8), `out_ovf`=1.
- 8 samples of 1000 (true sum -64):
  - with `TWOS_ACC_SAT_EN` -> `out_sum`=100000 (-32), `out_ovf`=1;
  - without -> `out_sum`=000000, `out_ovf`=1.
- HOLD with `out_ready`=0 for 5 cycles and `in_valid`=1 -> `out_valid`, `out_sum` and `out_ovf` stable, `in_ready`=0, no samples consumed. `out_ready`=1 -> `in_ready`=1 the next cycle.
- 3 samples of 0111, then `clear`, then 8 samples of 1111 -> `out_sum`=111000 (-8), `out_ovf`=0. `rst` asserted in the middle of the first frame gives the same result.
